// File: rtl/bnn_param_loader_if.sv
// bnn_param_loader_if: byte-stream and result handshake bundle for the BNN
// parameter loader. The master side is the SPI bridge / result consumer and
// the slave side is the loader itself.
interface bnn_param_loader_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [3:0] res_data;
    logic       res_valid;
    logic       res_ready;

    modport master (
        output s_data, s_valid, res_ready,
        input  s_ready, res_data, res_valid
    );

    modport slave (
        input  s_data, s_valid, res_ready,
        output s_ready, res_data, res_valid
    );
endinterface

// File: rtl/bnn_param_loader.sv
// bnn_param_loader: assembles weight, bias and input words for the 4-neuron
// binary MLP from an 8-bit valid/ready byte stream. It drives them as stable
// parallel buses, waits SETTLE_CYCLES, then returns the captured 4-bit MLP
// result over a valid/ready handshake.
// Optional feature: define BNN_LOADER_CHECKSUM_EN to add a 6th XOR checksum
// byte per frame and the sticky frame_err output.
module bnn_param_loader #(
    parameter int unsigned SETTLE_CYCLES = 2   // legal range 1..15
) (
    input  logic                clk,
    input  logic                reset,
    bnn_param_loader_if.slave   bus,
    input  logic                frame_abort,
    output logic [15:0]         bnn_weights,
    output logic [15:0]         bnn_bias,
    output logic [3:0]          bnn_input,
    input  logic [3:0]          bnn_result
`ifdef BNN_LOADER_CHECKSUM_EN
    ,
    output logic                frame_err
`endif
);

`ifdef BNN_LOADER_CHECKSUM_EN
    localparam logic [2:0] LAST_BYTE = 3'd5;
`else
    localparam logic [2:0] LAST_BYTE = 3'd4;
`endif
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        COLLECT,
        APPLY,
        SETTLE,
        RESULT
    } state_t;

    state_t      state;
    logic [2:0]  byte_cnt;
    logic [3:0]  settle_cnt;
    logic        ready_q;
    logic [15:0] w_shadow;
    logic [15:0] b_shadow;
    logic [3:0]  i_shadow;
    logic [3:0]  res_data_q;
    logic        res_valid_q;
    logic        accept;
`ifdef BNN_LOADER_CHECKSUM_EN
    logic [7:0]  xor_acc;
`endif

    // ready_q is only ever set while in COLLECT, so it doubles as the state
    // qualifier for byte acceptance; gating with reset keeps s_ready low
    // while reset is held and high as soon as it is released.
    assign bus.s_ready   = ready_q && !reset;
    assign bus.res_data  = res_data_q;
    assign bus.res_valid = res_valid_q;
    assign accept        = ready_q && bus.s_valid;

    // Frame FSM: collect bytes, apply shadows, wait out settle, hand back result.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the shadow registers are reset too, so a frame interrupted
            // by reset can never leak stale bytes into a later apply.
            state       <= COLLECT;
            byte_cnt    <= 3'd0;
            settle_cnt  <= 4'd0;
            ready_q     <= 1'b1;
            w_shadow    <= 16'h0;
            b_shadow    <= 16'h0;
            i_shadow    <= 4'h0;
            bnn_weights <= 16'h0;
            bnn_bias    <= 16'h0;
            bnn_input   <= 4'h0;
            res_data_q  <= 4'h0;
            res_valid_q <= 1'b0;
`ifdef BNN_LOADER_CHECKSUM_EN
            xor_acc     <= 8'h0;
            frame_err   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees
            // the pre-edge value of the state and counters.
            case (state)
                COLLECT: begin
                    if (frame_abort) begin
                        // Abort wins over a byte offered in the same cycle.
                        byte_cnt <= 3'd0;
                    end else if (accept) begin
                        case (byte_cnt)
                            3'd0:    w_shadow[15:8] <= bus.s_data;
                            3'd1:    w_shadow[7:0]  <= bus.s_data;
                            3'd2:    b_shadow[15:8] <= bus.s_data;
                            3'd3:    b_shadow[7:0]  <= bus.s_data;
                            3'd4:    i_shadow       <= bus.s_data[3:0];
                            default: ;
                        endcase
`ifdef BNN_LOADER_CHECKSUM_EN
                        xor_acc <= (byte_cnt == 3'd0) ? bus.s_data : (xor_acc ^ bus.s_data);
`endif
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt <= 3'd0;
`ifdef BNN_LOADER_CHECKSUM_EN
                            if (bus.s_data == xor_acc) begin
                                state   <= APPLY;
                                ready_q <= 1'b0;
                            end else begin
                                frame_err <= 1'b1;
                            end
`else
                            state   <= APPLY;
                            ready_q <= 1'b0;
`endif
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end
                end

                APPLY: begin
                    bnn_weights <= w_shadow;
                    bnn_bias    <= b_shadow;
                    bnn_input   <= i_shadow;
                    settle_cnt  <= SETTLE_LOAD;
                    state       <= SETTLE;
                end

                SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        res_data_q  <= bnn_result;
                        res_valid_q <= 1'b1;
                        state       <= RESULT;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end

                RESULT: begin
                    if (res_valid_q && bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        ready_q     <= 1'b1;
                        state       <= COLLECT;
                    end
                end

                default: begin
                    state   <= COLLECT;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule
